// File: rtl/picosoc_ws2812_chain_if.sv
// ---------------------------------------------------------------------------
// picosoc_ws2812_chain_if
// Purpose : picosoc iomem peripheral bus bundle used by the WS2812 chain
//           sequencer. The CPU side drives the request, the peripheral side
//           answers with ready/rdata.
// Signals :
//   iomem_valid  request, held by the master until iomem_ready
//   iomem_wstrb  byte strobes; any bit set = write, all zero = read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready is high
//   iomem_ready  one-cycle acknowledge from the peripheral
// ---------------------------------------------------------------------------
interface picosoc_ws2812_chain_if;
   logic        iomem_valid;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        iomem_ready;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_rdata,
      input  iomem_ready
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_rdata,
      output iomem_ready
   );
endinterface

// File: rtl/picosoc_ws2812_chain.sv
// ---------------------------------------------------------------------------
// picosoc_ws2812_chain
// Purpose : iomem-mapped sequencer for a daisy-chained WS2812 strip. Holds a
//           per-LED colour buffer, shifts it out GRB MSB-first with WS2812
//           bit timing, then holds the line low for the latch gap and pulses
//           done_irq once per frame.
// Ports   :
//   clk          system clock
//   reset        synchronous, active-high reset
//   bus          iomem slave (valid/wstrb/addr/wdata in, rdata/ready out)
//   done_irq     one-cycle pulse when a frame (including latch gap) finishes
//   ws2812_dout  registered serial data to the strip
// Map     : addr[8]=0 -> registers (0x00 CTRL, 0x04 COUNT)
//           addr[8]=1 -> pixel buffer, index addr[7:2], data {R,G,B}
// ---------------------------------------------------------------------------
module picosoc_ws2812_chain #(
   parameter int CLOCK_SPEED_HZ = 50_000_000,
   parameter int NUM_LEDS       = 8,
   parameter int T0H_NS         = 400,
   parameter int T1H_NS         = 800,
   parameter int TBIT_NS        = 1250,
   parameter int TLATCH_US      = 80
) (
   input  logic                         clk,
   input  logic                         reset,
   picosoc_ws2812_chain_if.slave        bus,
   output logic                         done_irq,
   output logic                         ws2812_dout
);

   // Cycle counts are clk_hz * ns / 1e9, truncated; done in 64 bits so the
   // product cannot overflow for realistic clocks.
   function automatic int nsToCycles(input longint ns);
      return int'((longint'(CLOCK_SPEED_HZ) * ns) / 64'sd1_000_000_000);
   endfunction

   localparam int T0H_CYC    = nsToCycles(longint'(T0H_NS));
   localparam int T1H_CYC    = nsToCycles(longint'(T1H_NS));
   localparam int TBIT_CYC   = nsToCycles(longint'(TBIT_NS));
   localparam int TLATCH_CYC = nsToCycles(longint'(TLATCH_US) * 64'sd1000);
   localparam int CNT_MAX    = (TBIT_CYC > TLATCH_CYC) ? TBIT_CYC : TLATCH_CYC;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);
   localparam int IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [CNT_W-1:0] T0H_LAST    = CNT_W'(T0H_CYC - 1);
   localparam logic [CNT_W-1:0] T1H_LAST    = CNT_W'(T1H_CYC - 1);
   localparam logic [CNT_W-1:0] TBIT_LAST   = CNT_W'(TBIT_CYC - 1);
   localparam logic [CNT_W-1:0] TLATCH_LAST = CNT_W'(TLATCH_CYC - 1);
   localparam logic [6:0]       NUM_LEDS_7  = 7'(NUM_LEDS);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HIGH,
      LOW,
      LATCH
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [6:0]        pixIdx_q;
   logic [4:0]        bitIdx_q;
   logic [23:0]       shiftReg_q;
   logic [6:0]        ledCount_q;
   logic              doneFlag_q;
   logic              irq_q;
   logic              dout_q;
   logic              ready_q;
   logic [31:0]       rdata_q;

   logic [23:0]       pixMem [0:(2**IDX_W)-1];

   logic              busy;
   logic              wrEn;
   logic              ctrlWr;
   logic              countWr;
   logic              pixWr;
   logic              pixIdxOk;
   logic [5:0]        regIdx;
   logic [6:0]        countSat;
   logic [CNT_W-1:0]  highLast;
   logic [31:0]       rdValue;
   logic              unusedBits;

   assign busy     = (state_q != IDLE);
   assign regIdx   = bus.iomem_addr[7:2];
   assign pixIdxOk = ({1'b0, regIdx} < NUM_LEDS_7);

   // A write takes effect on the handshake edge (valid and ready both high),
   // while address and data are still held by the master.
   assign wrEn     = bus.iomem_valid & ready_q & (|bus.iomem_wstrb);
   assign ctrlWr   = wrEn & ~bus.iomem_addr[8] & (regIdx == 6'd0);
   assign countWr  = wrEn & ~bus.iomem_addr[8] & (regIdx == 6'd1);
   assign pixWr    = wrEn &  bus.iomem_addr[8] & pixIdxOk;

   assign countSat = (bus.iomem_wdata[6:0] > NUM_LEDS_7) ? NUM_LEDS_7 : bus.iomem_wdata[6:0];
   assign highLast = shiftReg_q[23] ? T1H_LAST : T0H_LAST;

   assign unusedBits = ^{bus.iomem_addr[31:9], bus.iomem_addr[1:0],
                         bus.iomem_wdata[31:24], bus.iomem_wstrb[3]};

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;
   assign done_irq        = irq_q;
   assign ws2812_dout     = dout_q;

   // Read mux: register space or pixel buffer. Out-of-range pixel indices
   // and unmapped registers return zero.
   always_comb begin
      rdValue = '0;
      if (!bus.iomem_addr[8]) begin
         if (regIdx == 6'd0) begin
            rdValue = {30'b0, doneFlag_q, busy};
         end else if (regIdx == 6'd1) begin
            rdValue = {25'b0, ledCount_q};
         end
      end else if (pixIdxOk) begin
         rdValue = {8'b0, pixMem[bus.iomem_addr[IDX_W+1:2]]};
      end
   end

   // Bus acknowledge: ready rises one cycle after valid and drops right
   // after, so each request gets exactly one ready cycle. Read data is
   // captured alongside ready and is zero at all other times.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= bus.iomem_valid & ~ready_q;
         if (bus.iomem_valid && !ready_q && (bus.iomem_wstrb == 4'b0000)) begin
            rdata_q <= rdValue;
         end else begin
            rdata_q <= '0;
         end
      end
   end

   // Pixel buffer writes, byte by byte under the strobes. The buffer is not
   // reset and may be rewritten mid-frame; each pixel is only sampled when
   // the sequencer loads it.
   always_ff @(posedge clk) begin
      if (pixWr) begin
         if (bus.iomem_wstrb[0]) pixMem[bus.iomem_addr[IDX_W+1:2]][7:0]   <= bus.iomem_wdata[7:0];
         if (bus.iomem_wstrb[1]) pixMem[bus.iomem_addr[IDX_W+1:2]][15:8]  <= bus.iomem_wdata[15:8];
         if (bus.iomem_wstrb[2]) pixMem[bus.iomem_addr[IDX_W+1:2]][23:16] <= bus.iomem_wdata[23:16];
      end
   end

   // Frame sequencer. cnt_q counts cycles since entering HIGH for bit
   // timing, and cycles since entering LATCH for the latch gap. The
   // done-clear is applied before the end-of-frame set so that a clear
   // landing on the final cycle loses to the set. dout is updated on the
   // same edge as the state so it lines up with the state exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pixIdx_q   <= '0;
         bitIdx_q   <= '0;
         shiftReg_q <= '0;
         ledCount_q <= NUM_LEDS_7;
         doneFlag_q <= 1'b0;
         irq_q      <= 1'b0;
         dout_q     <= 1'b0;
      end else begin
         irq_q <= 1'b0;

         if (ctrlWr && bus.iomem_wstrb[0] && bus.iomem_wdata[1]) begin
            doneFlag_q <= 1'b0;
         end

         if (countWr && bus.iomem_wstrb[0] && !busy) begin
            ledCount_q <= countSat;
         end

         case (state_q)
            IDLE: begin
               dout_q <= 1'b0;
               if (ctrlWr && bus.iomem_wstrb[0] && bus.iomem_wdata[0]) begin
                  pixIdx_q <= '0;
                  cnt_q    <= '0;
                  state_q  <= (ledCount_q == 7'd0) ? LATCH : LOAD;
               end
            end

            LOAD: begin
               shiftReg_q <= {pixMem[pixIdx_q[IDX_W-1:0]][15:8],
                              pixMem[pixIdx_q[IDX_W-1:0]][23:16],
                              pixMem[pixIdx_q[IDX_W-1:0]][7:0]};
               bitIdx_q   <= 5'd23;
               cnt_q      <= '0;
               dout_q     <= 1'b1;
               state_q    <= HIGH;
            end

            HIGH: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == highLast) begin
                  dout_q  <= 1'b0;
                  state_q <= LOW;
               end
            end

            LOW: begin
               if (cnt_q == TBIT_LAST) begin
                  cnt_q <= '0;
                  if (bitIdx_q != 5'd0) begin
                     shiftReg_q <= {shiftReg_q[22:0], 1'b0};
                     bitIdx_q   <= bitIdx_q - 5'd1;
                     dout_q     <= 1'b1;
                     state_q    <= HIGH;
                  end else if ((pixIdx_q + 7'd1) < ledCount_q) begin
                     pixIdx_q <= pixIdx_q + 7'd1;
                     state_q  <= LOAD;
                  end else begin
                     state_q <= LATCH;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            LATCH: begin
               dout_q <= 1'b0;
               if (cnt_q == TLATCH_LAST) begin
                  doneFlag_q <= 1'b1;
                  irq_q      <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            default: begin
               dout_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_picosoc_ws2812_chain.sv
// ---------------------------------------------------------------------------
// tb_picosoc_ws2812_chain
// Purpose : self-checking bench for the WS2812 chain sequencer. Expected
//           pulses are queued when a frame is started; a monitor records
//           the pulses seen on ws2812_dout, and each scenario task pops both
//           queues and compares them.
// ---------------------------------------------------------------------------
module tb_picosoc_ws2812_chain;

   localparam int NUM_LEDS = 8;
   localparam int T0H      = 20;
   localparam int T1H      = 40;
   localparam int TBIT     = 62;
   localparam int TLATCH   = 4000;

   typedef struct {
      int width;
      int rise;
   } pulse_t;

   typedef struct {
      int width;
      int period;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic done_irq;
   logic ws2812_dout;

   picosoc_ws2812_chain_if bus();

   picosoc_ws2812_chain #(
      .NUM_LEDS(NUM_LEDS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .done_irq(done_irq),
      .ws2812_dout(ws2812_dout)
   );

   always #5 clk = ~clk;

   pulse_t      obsQ[$];
   exp_t        expQ[$];
   logic [23:0] model [NUM_LEDS];
   int          checks = 0;
   int          failures = 0;
   int          cycleCount = 0;
   int          irqCount = 0;
   int          lastIrqCycle = 0;
   int          riseCycle = 0;
   logic        prevDout = 1'b0;

   // Free-running cycle stamp used to time pulses.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Monitor: records each completed high pulse and every done_irq cycle,
   // sampled on the falling edge away from DUT updates.
   always @(negedge clk) begin
      if (ws2812_dout === 1'b1 && prevDout === 1'b0) riseCycle = cycleCount;
      if (ws2812_dout === 1'b0 && prevDout === 1'b1) obsQ.push_back('{width: cycleCount - riseCycle, rise: riseCycle});
      if (done_irq === 1'b1) begin
         irqCount++;
         lastIrqCycle = cycleCount;
      end
      prevDout = ws2812_dout;
   end

   // One bus transaction; returns read data and how many cycles ready was
   // seen high (the request window plus the cycle after it).
   task automatic busAccess(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output int readyCycles);
      int waitCount;
      waitCount   = 0;
      readyCycles = 0;
      rdata       = '0;
      @(posedge clk); #1;
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = addr;
      bus.iomem_wdata = wdata;
      bus.iomem_wstrb = strb;
      do begin
         @(negedge clk);
         waitCount++;
      end while (bus.iomem_ready !== 1'b1 && waitCount < 16);
      if (bus.iomem_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL bus_timeout addr=%h got=no ready expected=ready", addr);
      end else begin
         readyCycles = 1;
         rdata = bus.iomem_rdata;
      end
      @(posedge clk); #1;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
      @(negedge clk);
      if (bus.iomem_ready === 1'b1) readyCycles++;
   endtask

   task automatic writePixel(input int idx, input logic [23:0] val, input logic [3:0] strb);
      logic [31:0] rd;
      int rc;
      busAccess(32'h100 + 32'(idx) * 4, {8'h00, val}, strb, rd, rc);
      if (idx < NUM_LEDS) begin
         for (int b = 0; b < 3; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = val[8*b +: 8];
         end
      end
   endtask

   // Queue the 24 expected pulses of one pixel, GRB order, MSB first.
   // A period of 0 marks the first bit of a frame (not timed).
   task automatic pushPixel(input logic [23:0] rgb, input bit firstOfFrame);
      logic [23:0] grb;
      grb = {rgb[15:8], rgb[23:16], rgb[7:0]};
      for (int i = 23; i >= 0; i--) begin
         expQ.push_back('{width: grb[i] ? T1H : T0H,
                          period: (i == 23) ? (firstOfFrame ? 0 : TBIT + 1) : TBIT});
      end
   endtask

   task automatic waitIrq(input int irq0, input int maxCycles);
      int n;
      n = 0;
      while (irqCount == irq0 && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      if (irqCount == irq0) begin
         checks++;
         failures++;
         $display("[TB] FAIL irq_timeout got=no done_irq expected=done_irq within %0d cycles", maxCycles);
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int rc;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (ws2812_dout !== 1'b0 || done_irq !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=dout %b irq %b expected=0 0", ws2812_dout, done_irq);
      end
      busAccess(32'h00, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_ctrl got=%h expected=%h", rd, 32'h0); end
      checks++;
      if (rc !== 1) begin failures++; $display("[TB] FAIL ready_cycles_ctrl got=%0d expected=1", rc); end
      busAccess(32'h04, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'(NUM_LEDS)) begin failures++; $display("[TB] FAIL reset_count got=%h expected=%h", rd, NUM_LEDS); end
      checks++;
      if (rc !== 1) begin failures++; $display("[TB] FAIL ready_cycles_count got=%0d expected=1", rc); end
   endtask

   task automatic test_single_frame();
      logic [31:0] rd;
      int rc, irq0, prevRise;
      exp_t e;
      pulse_t o;
      writePixel(0, 24'hFF0080, 4'hF);
      busAccess(32'h04, 32'd1, 4'hF, rd, rc);
      obsQ.delete();
      expQ.delete();
      pushPixel(24'hFF0080, 1'b1);
      irq0 = irqCount;
      busAccess(32'h00, 32'h1, 4'hF, rd, rc);
      waitIrq(irq0, 20000);
      prevRise = 0;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL single_bit got=no pulse expected=width %0d", e.width);
         end else begin
            o = obsQ.pop_front();
            if (o.width !== e.width || (e.period != 0 && (o.rise - prevRise) !== e.period)) begin
               failures++;
               $display("[TB] FAIL single_bit got=w%0d p%0d expected=w%0d p%0d", o.width, o.rise - prevRise, e.width, e.period);
            end
            prevRise = o.rise;
         end
      end
      checks++;
      if ((lastIrqCycle - prevRise - TBIT) !== TLATCH) begin
         failures++;
         $display("[TB] FAIL latch_gap got=%0d expected=%0d", lastIrqCycle - prevRise - TBIT, TLATCH);
      end
      repeat (20) @(negedge clk);
      checks++;
      if ((irqCount - irq0) !== 1) begin failures++; $display("[TB] FAIL single_irq_pulses got=%0d expected=1", irqCount - irq0); end
      busAccess(32'h00, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h2) begin failures++; $display("[TB] FAIL single_ctrl got=%h expected=%h", rd, 32'h2); end
   endtask

   task automatic test_multi_frame();
      logic [31:0] rd;
      int rc, irq0, prevRise;
      exp_t e;
      pulse_t o;
      writePixel(0, 24'h123456, 4'hF);
      writePixel(1, 24'hA5C30F, 4'hF);
      writePixel(2, 24'h00FF01, 4'hF);
      busAccess(32'h04, 32'd3, 4'hF, rd, rc);
      obsQ.delete();
      expQ.delete();
      pushPixel(24'h123456, 1'b1);
      pushPixel(24'hA5C30F, 1'b0);
      pushPixel(24'h00FF01, 1'b0);
      irq0 = irqCount;
      busAccess(32'h00, 32'h1, 4'hF, rd, rc);
      waitIrq(irq0, 20000);
      prevRise = 0;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL multi_bit got=no pulse expected=width %0d", e.width);
         end else begin
            o = obsQ.pop_front();
            if (o.width !== e.width || (e.period != 0 && (o.rise - prevRise) !== e.period)) begin
               failures++;
               $display("[TB] FAIL multi_bit got=w%0d p%0d expected=w%0d p%0d", o.width, o.rise - prevRise, e.width, e.period);
            end
            prevRise = o.rise;
         end
      end
      checks++;
      if (obsQ.size() !== 0) begin failures++; $display("[TB] FAIL multi_extra_pulses got=%0d expected=0", obsQ.size()); end
   endtask

   task automatic test_busy_writes();
      logic [31:0] rd;
      int rc, irq0, prevRise;
      exp_t e;
      pulse_t o;
      writePixel(0, 24'h0F0F0F, 4'hF);
      writePixel(1, 24'h808080, 4'hF);
      busAccess(32'h04, 32'd2, 4'hF, rd, rc);
      obsQ.delete();
      expQ.delete();
      pushPixel(24'h0F0F0F, 1'b1);
      irq0 = irqCount;
      busAccess(32'h00, 32'h1, 4'hF, rd, rc);
      busAccess(32'h00, 32'h1, 4'hF, rd, rc);
      busAccess(32'h04, 32'd5, 4'hF, rd, rc);
      writePixel(1, 24'h3C5AA5, 4'hF);
      pushPixel(24'h3C5AA5, 1'b0);
      waitIrq(irq0, 20000);
      prevRise = 0;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL busy_bit got=no pulse expected=width %0d", e.width);
         end else begin
            o = obsQ.pop_front();
            if (o.width !== e.width || (e.period != 0 && (o.rise - prevRise) !== e.period)) begin
               failures++;
               $display("[TB] FAIL busy_bit got=w%0d p%0d expected=w%0d p%0d", o.width, o.rise - prevRise, e.width, e.period);
            end
            prevRise = o.rise;
         end
      end
      repeat (200) @(negedge clk);
      checks++;
      if ((irqCount - irq0) !== 1 || obsQ.size() !== 0) begin
         failures++;
         $display("[TB] FAIL busy_no_restart got=irqs %0d pulses %0d expected=irqs 1 pulses 0", irqCount - irq0, obsQ.size());
      end
      busAccess(32'h04, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'd2) begin failures++; $display("[TB] FAIL busy_count_kept got=%h expected=%h", rd, 32'd2); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] rd;
      int rc, irq0, n;
      busAccess(32'h04, 32'd3, 4'hF, rd, rc);
      obsQ.delete();
      irq0 = irqCount;
      busAccess(32'h00, 32'h1, 4'hF, rd, rc);
      n = 0;
      while (!(obsQ.size() >= 27 && ws2812_dout === 1'b1) && n < 10000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!(obsQ.size() >= 27 && ws2812_dout === 1'b1)) begin
         failures++;
         $display("[TB] FAIL midframe_reach got=pulses %0d expected=inside pixel 1 high", obsQ.size());
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (ws2812_dout !== 1'b0) begin failures++; $display("[TB] FAIL midframe_dout got=%b expected=0", ws2812_dout); end
      @(posedge clk); #1 reset = 1'b0;
      obsQ.delete();
      busAccess(32'h00, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL midframe_ctrl got=%h expected=%h", rd, 32'h0); end
      busAccess(32'h04, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'(NUM_LEDS)) begin failures++; $display("[TB] FAIL midframe_count got=%h expected=%h", rd, NUM_LEDS); end
      repeat (4200) @(negedge clk);
      checks++;
      if (irqCount !== irq0 || obsQ.size() !== 0) begin
         failures++;
         $display("[TB] FAIL midframe_quiet got=irqs %0d pulses %0d expected=irqs 0 pulses 0", irqCount - irq0, obsQ.size());
      end
   endtask

   task automatic test_restart();
      logic [31:0] rd;
      int rc, irq0, prevRise;
      exp_t e;
      pulse_t o;
      busAccess(32'h04, 32'd2, 4'hF, rd, rc);
      obsQ.delete();
      expQ.delete();
      pushPixel(model[0], 1'b1);
      pushPixel(model[1], 1'b0);
      irq0 = irqCount;
      busAccess(32'h00, 32'h1, 4'hF, rd, rc);
      waitIrq(irq0, 20000);
      prevRise = 0;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL restart_bit got=no pulse expected=width %0d", e.width);
         end else begin
            o = obsQ.pop_front();
            if (o.width !== e.width || (e.period != 0 && (o.rise - prevRise) !== e.period)) begin
               failures++;
               $display("[TB] FAIL restart_bit got=w%0d p%0d expected=w%0d p%0d", o.width, o.rise - prevRise, e.width, e.period);
            end
            prevRise = o.rise;
         end
      end
   endtask

   task automatic test_saturation();
      logic [31:0] rd;
      int rc;
      busAccess(32'h04, 32'd200, 4'hF, rd, rc);
      busAccess(32'h04, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'(NUM_LEDS)) begin failures++; $display("[TB] FAIL count_saturate got=%h expected=%h", rd, NUM_LEDS); end
      writePixel(NUM_LEDS, 24'hABCDEF, 4'hF);
      busAccess(32'h100 + 32'(NUM_LEDS) * 4, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL pixel_out_of_range got=%h expected=%h", rd, 32'h0); end
      writePixel(2, 24'h00AA00, 4'b0010);
      busAccess(32'h108, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h0000AA01) begin failures++; $display("[TB] FAIL pixel_byte_strobe got=%h expected=%h", rd, 32'h0000AA01); end
      busAccess(32'h08, 32'hFFFFFFFF, 4'hF, rd, rc);
      busAccess(32'h08, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL unmapped_reg got=%h expected=%h", rd, 32'h0); end
   endtask

   task automatic test_zero_count();
      logic [31:0] rd;
      int rc, irq0;
      busAccess(32'h04, 32'd0, 4'hF, rd, rc);
      obsQ.delete();
      irq0 = irqCount;
      busAccess(32'h00, 32'h1, 4'hF, rd, rc);
      waitIrq(irq0, 6000);
      repeat (5) @(negedge clk);
      checks++;
      if (obsQ.size() !== 0 || (irqCount - irq0) !== 1) begin
         failures++;
         $display("[TB] FAIL zero_count_frame got=pulses %0d irqs %0d expected=pulses 0 irqs 1", obsQ.size(), irqCount - irq0);
      end
      busAccess(32'h00, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h2) begin failures++; $display("[TB] FAIL zero_count_ctrl got=%h expected=%h", rd, 32'h2); end
   endtask

   task automatic test_done_clear();
      logic [31:0] rd;
      int rc, irq0, prevRise;
      exp_t e;
      pulse_t o;
      busAccess(32'h04, 32'd1, 4'hF, rd, rc);
      obsQ.delete();
      expQ.delete();
      pushPixel(model[0], 1'b1);
      irq0 = irqCount;
      busAccess(32'h00, 32'h3, 4'hF, rd, rc);
      busAccess(32'h00, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h1) begin failures++; $display("[TB] FAIL clear_and_start_ctrl got=%h expected=%h", rd, 32'h1); end
      waitIrq(irq0, 20000);
      prevRise = 0;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL clear_start_bit got=no pulse expected=width %0d", e.width);
         end else begin
            o = obsQ.pop_front();
            if (o.width !== e.width || (e.period != 0 && (o.rise - prevRise) !== e.period)) begin
               failures++;
               $display("[TB] FAIL clear_start_bit got=w%0d p%0d expected=w%0d p%0d", o.width, o.rise - prevRise, e.width, e.period);
            end
            prevRise = o.rise;
         end
      end
      busAccess(32'h00, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h2) begin failures++; $display("[TB] FAIL done_after_frame got=%h expected=%h", rd, 32'h2); end
      busAccess(32'h00, 32'h2, 4'hF, rd, rc);
      busAccess(32'h00, 32'h0, 4'h0, rd, rc);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("[TB] FAIL done_clear got=%h expected=%h", rd, 32'h0); end
   endtask

   initial begin
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
      bus.iomem_addr  = '0;
      bus.iomem_wdata = '0;
      reset           = 1'b1;
      for (int i = 0; i < NUM_LEDS; i++) model[i] = '0;
      test_reset();
      test_single_frame();
      test_multi_frame();
      test_busy_writes();
      test_reset_midframe();
      test_restart();
      test_saturation();
      test_zero_count();
      test_done_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
